// File: rtl/sdram_ch_arbiter.sv
// Purpose:      shares one 32-bit SDRAM channel (req/ready pulse protocol) among three
//               clients (0 = save memory, 1 = DMA, 2 = cart-ROM prefetch), round-robin.
// Latency:      cN_req at edge T -> mem_req high T+1..T+2; mem_ready at edge M -> cN_ready high M..M+1.
// Backpressure: one transaction outstanding; each client holds one pending slot, and a newer
//               request overwrites an ungranted one. A watchdog forces an error completion
//               after TIMEOUT silent WAIT cycles.
//
// Ports:
//   clk, reset                  rising-edge clock, asynchronous active-high reset
//   cN_addr/cN_din/cN_rnw/cN_req  client N request (sampled on the cN_req cycle)
//   cN_dout/cN_ready/cN_err       client N read data, completion pulse, sticky timeout flag
//   mem_addr/mem_din/mem_rnw/mem_req  downstream channel request (held from grant to completion)
//   mem_dout/mem_ready            downstream channel response
module sdram_ch_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [26:1] c0_addr,
  input  logic [31:0] c0_din,
  input  logic        c0_rnw,
  input  logic        c0_req,
  output logic [31:0] c0_dout,
  output logic        c0_ready,
  output logic        c0_err,

  input  logic [26:1] c1_addr,
  input  logic [31:0] c1_din,
  input  logic        c1_rnw,
  input  logic        c1_req,
  output logic [31:0] c1_dout,
  output logic        c1_ready,
  output logic        c1_err,

  input  logic [26:1] c2_addr,
  input  logic [31:0] c2_din,
  input  logic        c2_rnw,
  input  logic        c2_req,
  output logic [31:0] c2_dout,
  output logic        c2_ready,
  output logic        c2_err,

  output logic [26:1] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_rnw,
  output logic        mem_req,
  input  logic [31:0] mem_dout,
  input  logic        mem_ready
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // Client inputs gathered into indexable form.
  logic [26:1] in_addr [3];
  logic [31:0] in_din  [3];
  logic [2:0]  in_rnw;
  logic [2:0]  in_req;

  assign in_addr[0] = c0_addr;
  assign in_addr[1] = c1_addr;
  assign in_addr[2] = c2_addr;
  assign in_din[0]  = c0_din;
  assign in_din[1]  = c1_din;
  assign in_din[2]  = c2_din;
  assign in_rnw     = {c2_rnw, c1_rnw, c0_rnw};
  assign in_req     = {c2_req, c1_req, c0_req};

  // Per-client request slots.
  logic [26:1] slot_addr [3];
  logic [31:0] slot_din  [3];
  logic [2:0]  slot_rnw;
  logic [2:0]  pend;

  // Arbitration / transaction state.
  state_t      state;
  logic [1:0]  cur;
  logic [1:0]  last_grant;
  logic [15:0] wd;

  // Client-facing registered outputs.
  logic [31:0] dout_q [3];
  logic [2:0]  ready_q;
  logic [2:0]  err_q;

  assign c0_dout  = dout_q[0];
  assign c1_dout  = dout_q[1];
  assign c2_dout  = dout_q[2];
  assign c0_ready = ready_q[0];
  assign c1_ready = ready_q[1];
  assign c2_ready = ready_q[2];
  assign c0_err   = err_q[0];
  assign c1_err   = err_q[1];
  assign c2_err   = err_q[2];

  // Round-robin pick: scan last_grant+1, last_grant+2, then last_grant itself (mod 3).
  logic [1:0] cand1;
  logic [1:0] cand2;
  logic [1:0] win;
  logic       win_vld;

  always_comb begin
    cand1   = (last_grant == 2'd2) ? 2'd0 : last_grant + 2'd1;
    cand2   = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;
    win     = last_grant;
    win_vld = 1'b0;
    if (pend[cand1]) begin
      win     = cand1;
      win_vld = 1'b1;
    end else if (pend[cand2]) begin
      win     = cand2;
      win_vld = 1'b1;
    end else if (pend[last_grant]) begin
      win     = last_grant;
      win_vld = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cur        <= 2'd0;
      last_grant <= 2'd2;
      wd         <= 16'd0;
      pend       <= 3'b000;
      slot_rnw   <= 3'b111;
      ready_q    <= 3'b000;
      err_q      <= 3'b000;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= 32'd0;
      mem_rnw    <= 1'b1;
      for (int n = 0; n < 3; n++) begin
        slot_addr[n] <= '0;
        slot_din[n]  <= 32'd0;
        dout_q[n]    <= 32'd0;
      end
    end else begin
      mem_req <= 1'b0;
      ready_q <= 3'b000;

      case (state)
        S_IDLE: begin
          if (win_vld) begin
            mem_addr   <= slot_addr[win];
            mem_din    <= slot_din[win];
            mem_rnw    <= slot_rnw[win];
            mem_req    <= 1'b1;
            pend[win]  <= 1'b0;
            cur        <= win;
            wd         <= 16'(TIMEOUT);
            state      <= S_WAIT;
          end
        end

        S_WAIT: begin
          // mem_rnw still carries the in-flight direction; it is held until completion.
          if (mem_ready) begin
            if (mem_rnw) dout_q[cur] <= mem_dout;
            ready_q[cur] <= 1'b1;
            last_grant   <= cur;
            state        <= S_IDLE;
          end else if (wd == 16'd1) begin
            // TIMEOUT silent WAIT cycles elapsed: complete with an error.
            if (mem_rnw) dout_q[cur] <= ERR_DATA;
            err_q[cur]   <= 1'b1;
            ready_q[cur] <= 1'b1;
            last_grant   <= cur;
            state        <= S_IDLE;
          end else begin
            wd <= wd - 16'd1;
          end
        end

        default: state <= S_IDLE;
      endcase

      // Capture comes last so a request arriving on its own client's grant edge
      // stays pending (the grant already used the old slot), and a request on a
      // timeout edge leaves the err flag cleared.
      for (int n = 0; n < 3; n++) begin
        if (in_req[n]) begin
          slot_addr[n] <= in_addr[n];
          slot_din[n]  <= in_din[n];
          slot_rnw[n]  <= in_rnw[n];
          pend[n]      <= 1'b1;
          err_q[n]     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_ch_arbiter.sv
// Purpose:      randomized self-checking bench for sdram_ch_arbiter with a scoreboard of
//               expected completions and a transaction-level reference model.
// Latency:      stimulus driven on falling edges, DUT observed 1 time unit after rising edges.
// Backpressure: channel model answers after a chosen delay or never (watchdog path).
module tb_sdram_ch_arbiter;

  localparam int          TO   = 16;
  localparam logic [31:0] ERRD = 32'hFFFFFFFF;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [26:1] t_addr [3];
  logic [31:0] t_din  [3];
  logic [2:0]  t_rnw;
  logic [2:0]  t_req;

  logic [31:0] o_dout [3];
  logic [2:0]  o_ready;
  logic [2:0]  o_err;

  logic [26:1] mem_addr;
  logic [31:0] mem_din;
  logic        mem_rnw;
  logic        mem_req;
  logic [31:0] mem_dout;
  logic        mem_ready;

  sdram_ch_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .clk(clk), .reset(reset),
    .c0_addr(t_addr[0]), .c0_din(t_din[0]), .c0_rnw(t_rnw[0]), .c0_req(t_req[0]),
    .c0_dout(o_dout[0]), .c0_ready(o_ready[0]), .c0_err(o_err[0]),
    .c1_addr(t_addr[1]), .c1_din(t_din[1]), .c1_rnw(t_rnw[1]), .c1_req(t_req[1]),
    .c1_dout(o_dout[1]), .c1_ready(o_ready[1]), .c1_err(o_err[1]),
    .c2_addr(t_addr[2]), .c2_din(t_din[2]), .c2_rnw(t_rnw[2]), .c2_req(t_req[2]),
    .c2_dout(o_dout[2]), .c2_ready(o_ready[2]), .c2_err(o_err[2]),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_rnw(mem_rnw), .mem_req(mem_req),
    .mem_dout(mem_dout), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          cl;
    logic [31:0] dat;
    logic        err;
    int          at;
  } cpl_t;

  cpl_t        exp_q [$];
  logic [25:0] glog  [$];

  bit          busy_m;
  int          cur_m;
  int          last_m = 2;
  bit [2:0]    pend_m;
  logic [26:1] sa_m [3];
  logic [31:0] sd_m [3];
  logic [2:0]  sr_m;
  logic [31:0] dout_m [3];
  bit [2:0]    err_m;
  bit [2:0]    errk_m = 3'b111;
  int          cpl_edge_m;
  bit          cpl_to_m;
  logic [26:1] ha_m;
  logic [31:0] hd_m;
  logic        hr_m;
  int          rdy_cnt [3];

  // Channel plan, filled in by the model when it sees a grant.
  int          ch_edge   = -1;
  int          late_edge = -1;
  logic [31:0] ch_data;
  int          force_delay = 0;
  bit          force_data_en = 0;
  logic [31:0] force_data;

  int   m_w, m_d, m_to_cl;
  bit   m_anyp;
  cpl_t m_e;

  function automatic int rr_pick();
    int c;
    for (int k = 1; k <= 3; k++) begin
      c = (last_m + k) % 3;
      if (pend_m[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    #1;
    if (reset) begin
      busy_m = 0;
      pend_m = 3'b000;
      last_m = 2;
      exp_q.delete();
      err_m  = 3'b000;
      errk_m = 3'b111;
      for (int c = 0; c < 3; c++) dout_m[c] = 32'd0;
    end else begin
      m_to_cl = -1;
      if (!busy_m) begin
        m_anyp = (pend_m != 3'b000);
        check("grant_issue", 32'(mem_req), 32'(m_anyp));
        if (m_anyp && mem_req) begin
          m_w = rr_pick();
          check("grant_addr", 32'(mem_addr), 32'(sa_m[m_w]));
          check("grant_din", mem_din, sd_m[m_w]);
          check("grant_rnw", 32'(mem_rnw), 32'(sr_m[m_w]));
          glog.push_back(mem_addr);
          ha_m = sa_m[m_w]; hd_m = sd_m[m_w]; hr_m = sr_m[m_w];
          cur_m = m_w; busy_m = 1; pend_m[m_w] = 1'b0;
          if (force_delay > 0)      m_d = force_delay;
          else if (force_delay < 0) m_d = -1;
          else m_d = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, 12));
          if (m_d < 0) begin
            cpl_edge_m = cyc + TO;
            cpl_to_m   = 1;
            ch_edge    = -1;
            late_edge  = cyc + TO + 1;
            m_e.dat    = hr_m ? ERRD : dout_m[m_w];
            m_e.err    = 1'b1;
          end else begin
            cpl_edge_m = cyc + m_d;
            cpl_to_m   = 0;
            ch_data    = force_data_en ? force_data : $urandom;
            ch_edge    = cpl_edge_m;
            m_e.dat    = hr_m ? ch_data : dout_m[m_w];
            m_e.err    = 1'b0;
          end
          m_e.cl = m_w;
          m_e.at = cpl_edge_m;
          dout_m[m_w] = m_e.dat;
          exp_q.push_back(m_e);
        end
      end else begin
        check("mem_req_pulse", 32'(mem_req), 32'd0);
        check("hold_addr", 32'(mem_addr), 32'(ha_m));
        check("hold_din", mem_din, hd_m);
        check("hold_rnw", 32'(mem_rnw), 32'(hr_m));
        if (cyc == cpl_edge_m) begin
          busy_m = 0;
          last_m = cur_m;
          if (cpl_to_m) begin
            err_m[cur_m] = 1'b1;
            m_to_cl = cur_m;
          end
        end
      end

      // Scoreboard: every completion pulse the DUT shows must match the queue head.
      if (o_ready != 3'b000) begin
        for (int c = 0; c < 3; c++) if (o_ready[c]) rdy_cnt[c]++;
        if (exp_q.size() == 0) begin
          check("spurious_ready", 32'(o_ready), 32'd0);
        end else begin
          m_e = exp_q.pop_front();
          check("ready_client", 32'(o_ready), 32'd1 << m_e.cl);
          check("ready_cycle", cyc, m_e.at);
          check("ready_dout", o_dout[m_e.cl], m_e.dat);
        end
      end

      for (int c = 0; c < 3; c++) begin
        if (t_req[c]) begin
          pend_m[c] = 1'b1;
          sa_m[c]   = t_addr[c];
          sd_m[c]   = t_din[c];
          sr_m[c]   = t_rnw[c];
          err_m[c]  = 1'b0;
          // A request landing on its own timeout edge leaves the flag ambiguous.
          errk_m[c] = (m_to_cl != c);
        end
      end

      for (int c = 0; c < 3; c++)
        if (errk_m[c]) check("err_flag", 32'(o_err[c]), 32'(err_m[c]));
    end
  end

  // ---------------- channel model ----------------
  initial begin
    mem_ready = 1'b0;
    mem_dout  = 32'd0;
    forever begin
      @(negedge clk);
      if (cyc + 1 == ch_edge) begin
        mem_ready = 1'b1;
        mem_dout  = ch_data;
      end else if (cyc + 1 == late_edge) begin
        mem_ready = 1'b1;
        mem_dout  = $urandom;
      end else begin
        mem_ready = 1'b0;
        mem_dout  = $urandom;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    t_req = 3'b000;
  endtask

  task automatic set_req(int c, logic [26:1] a, logic [31:0] d, logic r);
    t_req[c]  = 1'b1;
    t_addr[c] = a;
    t_din[c]  = d;
    t_rnw[c]  = r;
  endtask

  task automatic wait_idle(int max);
    for (int i = 0; i < max; i++) begin
      step();
      if (!busy_m && pend_m == 3'b000 && exp_q.size() == 0) return;
    end
    n_chk++;
    $display("FAIL wait_idle: DUT still busy after %0d cycles, required idle", max);
  endtask

  task automatic check_reset_vals();
    for (int c = 0; c < 3; c++) begin
      check("rst_dout", o_dout[c], 32'd0);
      check("rst_ready", 32'(o_ready[c]), 32'd0);
      check("rst_err", 32'(o_err[c]), 32'd0);
    end
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_din", mem_din, 32'd0);
    check("rst_mem_rnw", 32'(mem_rnw), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    t_req = 3'b000;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  int c0_before;

  initial begin
    t_req = 3'b000;
    t_rnw = 3'b111;
    for (int c = 0; c < 3; c++) begin
      t_addr[c] = '0;
      t_din[c]  = 32'd0;
    end
    repeat (3) @(negedge clk);
    check_reset_vals();
    reset = 1'b0;

    // Single read on client 1, channel answers after 8 cycles.
    force_delay = 8; force_data_en = 1; force_data = 32'hDEADBEEF;
    step(); set_req(1, 26'h0000100, $urandom, 1'b1);
    wait_idle(40);
    check("single_read_dout", o_dout[1], 32'hDEADBEEF);
    force_data_en = 0;

    // Simultaneous reads straight after reset: order 0,1,2.
    do_reset();
    force_delay = 0;
    glog.delete();
    step();
    for (int c = 0; c < 3; c++) set_req(c, 26'(c), $urandom, 1'b1);
    wait_idle(200);
    check("simul_count", glog.size(), 3);
    for (int i = 0; i < 3 && i < glog.size(); i++) check("simul_order", 32'(glog[i]), i);

    // Continuous requests from all three: strict 0,1,2 rotation.
    force_delay = 2;
    glog.delete();
    repeat (40) begin
      step();
      for (int c = 0; c < 3; c++) set_req(c, 26'(c), $urandom, 1'b1);
    end
    wait_idle(100);
    check("cont_enough", 32'(glog.size() >= 9), 32'd1);
    for (int i = 0; i < glog.size(); i++) check("cont_order", 32'(glog[i]), i % 3);

    // Write then read on client 2.
    force_delay = 5;
    step(); set_req(2, 26'h0002000, 32'h12345678, 1'b0);
    wait_idle(40);
    check("write_keeps_dout", o_dout[2], dout_m[2]);
    force_delay = 4;
    step(); set_req(2, 26'h0002000, $urandom, 1'b1);
    wait_idle(40);
    check("read_after_write", o_dout[2], dout_m[2]);

    // Overwrite: c0 asks for A then B while c1 is in flight.
    force_delay = 10;
    glog.delete();
    c0_before = rdy_cnt[0];
    step(); set_req(1, 26'h0000111, $urandom, 1'b1);
    step(); step();
    set_req(0, 26'h0000AAA, $urandom, 1'b1);
    step(); step();
    set_req(0, 26'h0000BBB, $urandom, 1'b1);
    wait_idle(60);
    check("ovr_grants", glog.size(), 2);
    if (glog.size() == 2) check("ovr_addr_b", 32'(glog[1]), 32'h0000BBB);
    check("ovr_one_ready", rdy_cnt[0] - c0_before, 1);

    // Timeout: channel never answers a c1 read; late answer must be ignored.
    force_delay = -1;
    step(); set_req(1, 26'h0000300, $urandom, 1'b1);
    wait_idle(60);
    repeat (3) step();
    check("to_err", 32'(o_err[1]), 32'd1);
    check("to_dout", o_dout[1], ERRD);
    force_delay = 3;
    step(); set_req(1, 26'h0000301, $urandom, 1'b1);
    step();
    check("to_err_clear", 32'(o_err[1]), 32'd0);
    wait_idle(40);

    // Reset during WAIT with c0 and c2 pending.
    force_delay = 12;
    step(); set_req(1, 26'h0000400, $urandom, 1'b1);
    step(); step();
    set_req(0, 26'h0000401, $urandom, 1'b1);
    set_req(2, 26'h0000402, $urandom, 1'b1);
    step(); step();
    reset = 1'b1;
    #1;
    check_reset_vals();
    step(); step();
    reset = 1'b0;
    repeat (15) step();
    check("rst_no_ready", rdy_cnt[0] + rdy_cnt[2] - rdy_cnt[0] - rdy_cnt[2] + 32'(o_ready), 32'd0);
    force_delay = 0;
    c0_before = rdy_cnt[2];
    step(); set_req(2, 26'h0000500, $urandom, 1'b1);
    wait_idle(60);
    check("post_rst_served", rdy_cnt[2] - c0_before, 1);

    // Random traffic.
    force_delay = 0;
    repeat (1500) begin
      step();
      for (int c = 0; c < 3; c++)
        if ($urandom_range(0, 9) == 0) set_req(c, 26'($urandom), $urandom, 1'($urandom));
    end
    wait_idle(500);
    repeat (3) step();
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
